// File: rtl/lm32_wb_arb_pkg.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lm32_wb_arb_pkg: state encoding and shared constants for the LM32 arbiter. Rev 1.0
// -----------------------------------------------------------------------------
package lm32_wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GNT_I = 2'd1,
    ST_GNT_D = 2'd2
  } arb_state_e;

  localparam logic [2:0] c_CTI_CLASSIC = 3'b000;
  localparam logic [2:0] c_CTI_END     = 3'b111;
  localparam int         c_WDT_W       = 8;

endpackage
`default_nettype wire

// File: rtl/lm32_wb_arb_watchdog.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lm32_wb_arb_watchdog: counts unanswered strobe cycles, flags the limit. Rev 1.0
// -----------------------------------------------------------------------------
module lm32_wb_arb_watchdog
  import lm32_wb_arb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               i_run,
  input  logic               i_clear,
  input  logic [c_WDT_W-1:0] i_limit,
  output logic               o_expire
);

  logic [c_WDT_W-1:0] r_count;
  logic               w_enabled;

  assign w_enabled = (i_limit != '0);
  assign o_expire  = w_enabled && (r_count == i_limit);

  // A zero limit pins the counter at zero so it can never expire.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else if (i_clear || o_expire || !w_enabled) begin
      r_count <= '0;
    end else if (i_run) begin
      r_count <= r_count + c_WDT_W'(1);
    end
  end

endmodule
`default_nettype wire

// File: rtl/lm32_wb_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// lm32_wb_arbiter: round-robin Wishbone arbiter, LM32 I/D masters to one slave. Rev 1.0
// -----------------------------------------------------------------------------
module lm32_wb_arbiter
  import lm32_wb_arb_pkg::*;
#(
  parameter int AW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          iwb_cyc_i,
  input  logic          iwb_stb_i,
  input  logic          iwb_we_i,
  input  logic [3:0]    iwb_sel_i,
  input  logic [AW-1:0] iwb_adr_i,
  input  logic [31:0]   iwb_dat_i,
  input  logic [2:0]    iwb_cti_i,
  input  logic [1:0]    iwb_bte_i,
  output logic [31:0]   iwb_dat_o,
  output logic          iwb_ack_o,
  output logic          iwb_err_o,
  output logic          iwb_rty_o,
  input  logic          dwb_cyc_i,
  input  logic          dwb_stb_i,
  input  logic          dwb_we_i,
  input  logic [3:0]    dwb_sel_i,
  input  logic [AW-1:0] dwb_adr_i,
  input  logic [31:0]   dwb_dat_i,
  input  logic [2:0]    dwb_cti_i,
  input  logic [1:0]    dwb_bte_i,
  output logic [31:0]   dwb_dat_o,
  output logic          dwb_ack_o,
  output logic          dwb_err_o,
  output logic          dwb_rty_o,
  output logic          swb_cyc_o,
  output logic          swb_stb_o,
  output logic          swb_we_o,
  output logic [3:0]    swb_sel_o,
  output logic [AW-1:0] swb_adr_o,
  output logic [31:0]   swb_dat_o,
  output logic [2:0]    swb_cti_o,
  output logic [1:0]    swb_bte_o,
  input  logic [31:0]   swb_dat_i,
  input  logic          swb_ack_i,
  input  logic          swb_err_i,
  input  logic          swb_rty_i
);

  localparam logic [c_WDT_W-1:0] c_LIMIT = c_WDT_W'(TIMEOUT);

  arb_state_e r_state;
  arb_state_e w_state_nxt;
  logic       r_last_gnt;
  logic       w_last_gnt_nxt;
  logic       w_gnt_i;
  logic       w_gnt_d;
  logic       w_active;
  logic       w_resp;
  logic       w_wd_expire;
  logic       w_timeout;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_state    <= ST_IDLE;
      r_last_gnt <= 1'b1;
    end else begin
      r_state    <= w_state_nxt;
      r_last_gnt <= w_last_gnt_nxt;
    end
  end

  // Release hands straight over to a waiting master, so there is no idle bubble.
  always_comb begin
    w_state_nxt    = r_state;
    w_last_gnt_nxt = r_last_gnt;
    case (r_state)
      ST_IDLE: begin
        if (iwb_cyc_i && dwb_cyc_i) begin
          w_state_nxt = r_last_gnt ? ST_GNT_I : ST_GNT_D;
        end else if (iwb_cyc_i) begin
          w_state_nxt = ST_GNT_I;
        end else if (dwb_cyc_i) begin
          w_state_nxt = ST_GNT_D;
        end
      end
      ST_GNT_I: begin
        if (!iwb_cyc_i) begin
          w_last_gnt_nxt = 1'b0;
          w_state_nxt    = dwb_cyc_i ? ST_GNT_D : ST_IDLE;
        end
      end
      ST_GNT_D: begin
        if (!dwb_cyc_i) begin
          w_last_gnt_nxt = 1'b1;
          w_state_nxt    = iwb_cyc_i ? ST_GNT_I : ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  assign w_gnt_i   = (r_state == ST_GNT_I);
  assign w_gnt_d   = (r_state == ST_GNT_D);
  assign w_active  = (w_gnt_i & iwb_cyc_i & iwb_stb_i) | (w_gnt_d & dwb_cyc_i & dwb_stb_i);
  assign w_resp    = swb_ack_i | swb_err_i | swb_rty_i;
  assign w_timeout = w_wd_expire & w_active;

  lm32_wb_arb_watchdog u_watchdog (
    .clk      (clk_i),
    .rst      (rst_i),
    .i_run    (w_active & ~w_resp),
    .i_clear  (~w_active | w_resp | (w_state_nxt != r_state)),
    .i_limit  (c_LIMIT),
    .o_expire (w_wd_expire)
  );

  assign iwb_dat_o = swb_dat_i;
  assign dwb_dat_o = swb_dat_i;

  always_comb begin
    swb_cyc_o = 1'b0;
    swb_stb_o = 1'b0;
    swb_we_o  = 1'b0;
    swb_sel_o = '0;
    swb_adr_o = '0;
    swb_dat_o = '0;
    swb_cti_o = '0;
    swb_bte_o = '0;
    iwb_ack_o = 1'b0;
    iwb_err_o = 1'b0;
    iwb_rty_o = 1'b0;
    dwb_ack_o = 1'b0;
    dwb_err_o = 1'b0;
    dwb_rty_o = 1'b0;
    if (w_gnt_i) begin
      swb_cyc_o = iwb_cyc_i;
      swb_stb_o = iwb_stb_i & ~w_timeout;
      swb_we_o  = iwb_we_i;
      swb_sel_o = iwb_sel_i;
      swb_adr_o = iwb_adr_i;
      swb_dat_o = iwb_dat_i;
      swb_cti_o = iwb_cti_i;
      swb_bte_o = iwb_bte_i;
      iwb_ack_o = swb_ack_i;
      iwb_err_o = swb_err_i | w_timeout;
      iwb_rty_o = swb_rty_i;
    end else if (w_gnt_d) begin
      swb_cyc_o = dwb_cyc_i;
      swb_stb_o = dwb_stb_i & ~w_timeout;
      swb_we_o  = dwb_we_i;
      swb_sel_o = dwb_sel_i;
      swb_adr_o = dwb_adr_i;
      swb_dat_o = dwb_dat_i;
      swb_cti_o = dwb_cti_i;
      swb_bte_o = dwb_bte_i;
      dwb_ack_o = swb_ack_i;
      dwb_err_o = swb_err_i | w_timeout;
      dwb_rty_o = swb_rty_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_lm32_wb_arbiter.sv
`default_nettype none
// -----------------------------------------------------------------------------
// tb_lm32_wb_arbiter: directed and random checks against a transaction-level model. Rev 1.0
// -----------------------------------------------------------------------------
module tb_lm32_wb_arbiter;
  import lm32_wb_arb_pkg::*;

  localparam int          AW   = 32;
  localparam logic [31:0] c_IA = 32'h0000_1000;
  localparam logic [31:0] c_DA = 32'h0000_2000;

  logic            clk = 1'b0;
  logic            rst_i;
  logic            iwb_cyc_i, iwb_stb_i, iwb_we_i, dwb_cyc_i, dwb_stb_i, dwb_we_i;
  logic [3:0]      iwb_sel_i, dwb_sel_i;
  logic [AW-1:0]   iwb_adr_i, dwb_adr_i;
  logic [31:0]     iwb_dat_i, dwb_dat_i, swb_dat_i;
  logic [2:0]      iwb_cti_i, dwb_cti_i;
  logic [1:0]      iwb_bte_i, dwb_bte_i;
  logic            swb_ack_i, swb_err_i, swb_rty_i;

  // Instance 0 has TIMEOUT=4, instance 1 has the watchdog disabled.
  logic [1:0][31:0]   iwb_dat_o, dwb_dat_o, swb_dat_o;
  logic [1:0]         iwb_ack_o, iwb_err_o, iwb_rty_o, dwb_ack_o, dwb_err_o, dwb_rty_o;
  logic [1:0]         swb_cyc_o, swb_stb_o, swb_we_o;
  logic [1:0][3:0]    swb_sel_o;
  logic [1:0][AW-1:0] swb_adr_o;
  logic [1:0][2:0]    swb_cti_o;
  logic [1:0][1:0]    swb_bte_o;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_dut
    lm32_wb_arbiter #(.AW(AW), .TIMEOUT(g == 0 ? 4 : 0)) u_dut (
      .clk_i(clk), .rst_i(rst_i),
      .iwb_cyc_i(iwb_cyc_i), .iwb_stb_i(iwb_stb_i), .iwb_we_i(iwb_we_i), .iwb_sel_i(iwb_sel_i),
      .iwb_adr_i(iwb_adr_i), .iwb_dat_i(iwb_dat_i), .iwb_cti_i(iwb_cti_i), .iwb_bte_i(iwb_bte_i),
      .iwb_dat_o(iwb_dat_o[g]), .iwb_ack_o(iwb_ack_o[g]), .iwb_err_o(iwb_err_o[g]), .iwb_rty_o(iwb_rty_o[g]),
      .dwb_cyc_i(dwb_cyc_i), .dwb_stb_i(dwb_stb_i), .dwb_we_i(dwb_we_i), .dwb_sel_i(dwb_sel_i),
      .dwb_adr_i(dwb_adr_i), .dwb_dat_i(dwb_dat_i), .dwb_cti_i(dwb_cti_i), .dwb_bte_i(dwb_bte_i),
      .dwb_dat_o(dwb_dat_o[g]), .dwb_ack_o(dwb_ack_o[g]), .dwb_err_o(dwb_err_o[g]), .dwb_rty_o(dwb_rty_o[g]),
      .swb_cyc_o(swb_cyc_o[g]), .swb_stb_o(swb_stb_o[g]), .swb_we_o(swb_we_o[g]), .swb_sel_o(swb_sel_o[g]),
      .swb_adr_o(swb_adr_o[g]), .swb_dat_o(swb_dat_o[g]), .swb_cti_o(swb_cti_o[g]), .swb_bte_o(swb_bte_o[g]),
      .swb_dat_i(swb_dat_i), .swb_ack_i(swb_ack_i), .swb_err_i(swb_err_i), .swb_rty_i(swb_rty_i)
    );
  end

  int checks = 0;
  int errors = 0;
  int owner;
  int tie;
  int wd  [2];
  int lim [2] = '{4, 0};

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Model: owner is -1 (nobody), 0 (I) or 1 (D); tie is who wins the next tie.
  task automatic cycle();
    logic [75:0] ireq, dreq, ereq;
    logic [5:0]  ersp;
    logic        act, resp, s;
    logic        to [2];
    int          nxt;
    @(negedge clk);
    act  = (owner == 0) ? (iwb_cyc_i & iwb_stb_i) : (owner == 1) ? (dwb_cyc_i & dwb_stb_i) : 1'b0;
    resp = swb_ack_i | swb_err_i | swb_rty_i;
    ireq = {iwb_cyc_i, iwb_stb_i, iwb_we_i, iwb_sel_i, iwb_adr_i, iwb_dat_i, iwb_cti_i, iwb_bte_i};
    dreq = {dwb_cyc_i, dwb_stb_i, dwb_we_i, dwb_sel_i, dwb_adr_i, dwb_dat_i, dwb_cti_i, dwb_bte_i};
    for (int g = 0; g < 2; g++) begin
      s     = 1'(g);
      to[s] = act && (lim[s] != 0) && (wd[s] == lim[s]);
      ereq  = (owner == 0) ? ireq : (owner == 1) ? dreq : 76'd0;
      if (to[s]) ereq[74] = 1'b0;
      ersp = 6'd0;
      if (owner == 0) ersp[2:0] = {swb_ack_i, swb_err_i | to[s], swb_rty_i};
      if (owner == 1) ersp[5:3] = {swb_ack_i, swb_err_i | to[s], swb_rty_i};
      chk($sformatf("req%0d", g),
          128'({swb_cyc_o[s], swb_stb_o[s], swb_we_o[s], swb_sel_o[s], swb_adr_o[s],
                swb_dat_o[s], swb_cti_o[s], swb_bte_o[s]}), 128'(ereq));
      chk($sformatf("rsp%0d", g),
          128'({dwb_ack_o[s], dwb_err_o[s], dwb_rty_o[s], iwb_ack_o[s], iwb_err_o[s], iwb_rty_o[s]}),
          128'(ersp));
      chk($sformatf("dat%0d", g), 128'({iwb_dat_o[s], dwb_dat_o[s]}), 128'({swb_dat_i, swb_dat_i}));
    end
    nxt = owner;
    if (owner < 0) begin
      if (iwb_cyc_i && dwb_cyc_i) nxt = tie;
      else if (iwb_cyc_i)         nxt = 0;
      else if (dwb_cyc_i)         nxt = 1;
    end else if (!((owner == 0) ? iwb_cyc_i : dwb_cyc_i)) begin
      tie = 1 - owner;
      nxt = ((owner == 0) ? dwb_cyc_i : iwb_cyc_i) ? 1 - owner : -1;
    end
    for (int g = 0; g < 2; g++) begin
      s     = 1'(g);
      wd[s] = (!act || resp || to[s] || lim[s] == 0 || nxt != owner) ? 0 : wd[s] + 1;
    end
    owner = nxt;
    if (rst_i) begin
      owner = -1;
      tie   = 0;
      wd[0] = 0;
      wd[1] = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    rst_i = 1'b0;
    {iwb_cyc_i, iwb_stb_i, iwb_we_i, dwb_cyc_i, dwb_stb_i, dwb_we_i} = '0;
    {iwb_sel_i, dwb_sel_i, iwb_cti_i, dwb_cti_i, iwb_bte_i, dwb_bte_i} = '0;
    {iwb_adr_i, dwb_adr_i, iwb_dat_i, dwb_dat_i, swb_dat_i} = '0;
    {swb_ack_i, swb_err_i, swb_rty_i} = '0;
  endtask

  task automatic do_reset();
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
  endtask

  initial begin
    clear_inputs();
    rst_i = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    owner = -1;
    tie   = 0;
    wd[0] = 0;
    wd[1] = 0;

    // Reset holds everything quiet even with a live request and response.
    iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1; iwb_adr_i = 32'h100; swb_ack_i = 1'b1;
    #1;
    chk("reset_cyc", 128'(swb_cyc_o[0]), 128'(0));
    chk("reset_ack", 128'(iwb_ack_o[0]), 128'(0));
    cycle();
    rst_i = 1'b0; swb_ack_i = 1'b0;
    #1;
    chk("rd_lat_cyc0", 128'(swb_cyc_o[0]), 128'(0));
    cycle();
    swb_ack_i = 1'b1; swb_dat_i = 32'hDEADBEEF;
    #1;
    chk("rd_cyc1", 128'(swb_cyc_o[0]), 128'(1));
    chk("rd_adr", 128'(swb_adr_o[0]), 128'(32'h100));
    chk("rd_iack", 128'(iwb_ack_o[0]), 128'(1));
    chk("rd_idat", 128'(iwb_dat_o[0]), 128'(32'hDEADBEEF));
    chk("rd_dack", 128'(dwb_ack_o[0]), 128'(0));
    cycle();
    clear_inputs();
    cycle();

    // Round-robin under continuous contention.
    do_reset();
    iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1; iwb_adr_i = c_IA;
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_adr_i = c_DA;
    cycle();
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("rr_adr", 128'(swb_adr_o[0]), 128'((k % 2 == 0) ? c_IA : c_DA));
      chk("rr_cyc", 128'(swb_cyc_o[0]), 128'(1));
      cycle();
      if (k % 2 == 0) {iwb_cyc_i, iwb_stb_i} = 2'b00;
      else            {dwb_cyc_i, dwb_stb_i} = 2'b00;
      cycle();
      {iwb_cyc_i, iwb_stb_i, dwb_cyc_i, dwb_stb_i} = 4'b1111;
    end
    clear_inputs();
    cycle();

    // D burst is never split by a competing I request.
    do_reset();
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_adr_i = c_DA; dwb_cti_i = 3'b010;
    cycle();
    iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1; iwb_adr_i = c_IA;
    for (int b = 0; b < 4; b++) begin
      dwb_cti_i = (b == 3) ? c_CTI_END : 3'b010;
      dwb_adr_i = c_DA + 32'(b);
      swb_ack_i = 1'b1;
      #1;
      chk("bst_dack", 128'(dwb_ack_o[0]), 128'(1));
      chk("bst_iack", 128'(iwb_ack_o[0]), 128'(0));
      chk("bst_cti", 128'(swb_cti_o[0]), 128'((b == 3) ? 3'b111 : 3'b010));
      cycle();
    end
    dwb_cyc_i = 1'b0; dwb_stb_i = 1'b0; swb_ack_i = 1'b0;
    cycle();
    #1;
    chk("bst_next_adr", 128'(swb_adr_o[0]), 128'(c_IA));
    chk("bst_next_cyc", 128'(swb_cyc_o[0]), 128'(1));
    cycle();
    clear_inputs();
    cycle();

    // Silent slave: err pulse four cycles after strobe, strobe masked that cycle.
    do_reset();
    iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1; iwb_adr_i = c_IA;
    cycle();
    for (int k = 1; k <= 6; k++) begin
      #1;
      chk("wd_err", 128'(iwb_err_o[0]), 128'(k == 5));
      chk("wd_stb", 128'(swb_stb_o[0]), 128'(k != 5));
      chk("wd_off_err", 128'(iwb_err_o[1]), 128'(0));
      cycle();
    end
    clear_inputs();
    cycle();

    // Reset in the middle of a D transfer.
    do_reset();
    dwb_cyc_i = 1'b1; dwb_stb_i = 1'b1; dwb_adr_i = c_DA;
    cycle();
    #1;
    chk("rst_pre_cyc", 128'(swb_cyc_o[0]), 128'(1));
    rst_i = 1'b1;
    cycle();
    rst_i = 1'b0;
    iwb_cyc_i = 1'b1; iwb_stb_i = 1'b1; iwb_adr_i = c_IA;
    swb_ack_i = 1'b1; swb_err_i = 1'b1;
    #1;
    chk("rst_cyc", 128'(swb_cyc_o[0]), 128'(0));
    chk("rst_dack", 128'(dwb_ack_o[0]), 128'(0));
    chk("rst_derr", 128'(dwb_err_o[0]), 128'(0));
    cycle();
    swb_ack_i = 1'b0; swb_err_i = 1'b0;
    #1;
    chk("rst_tie_adr", 128'(swb_adr_o[0]), 128'(c_IA));
    cycle();
    clear_inputs();
    cycle();

    // Random traffic with persistent master cycles.
    for (int n = 0; n < 3000; n++) begin
      rst_i     = ($urandom_range(0, 299) == 0);
      iwb_cyc_i = iwb_cyc_i ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      dwb_cyc_i = dwb_cyc_i ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 3) == 0);
      iwb_stb_i = iwb_cyc_i & ($urandom_range(0, 4) != 0);
      dwb_stb_i = dwb_cyc_i & ($urandom_range(0, 4) != 0);
      iwb_we_i  = 1'($urandom);
      dwb_we_i  = 1'($urandom);
      iwb_sel_i = 4'($urandom);
      dwb_sel_i = 4'($urandom);
      iwb_adr_i = $urandom;
      dwb_adr_i = $urandom;
      iwb_dat_i = $urandom;
      dwb_dat_i = $urandom;
      iwb_cti_i = 3'($urandom);
      dwb_cti_i = 3'($urandom);
      iwb_bte_i = 2'($urandom);
      dwb_bte_i = 2'($urandom);
      swb_dat_i = $urandom;
      swb_ack_i = ($urandom_range(0, 3) == 0);
      swb_err_i = ($urandom_range(0, 31) == 0);
      swb_rty_i = ($urandom_range(0, 31) == 0);
      cycle();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
